// File: rtl/tl_sram_resp.sv
// tl_sram_resp: single-outstanding TileLink-UL SRAM slave with one-cycle response latency
module tl_sram_resp #(
  parameter int          DEPTH = 512,
  parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [63:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic        d_denied,
  output logic [63:0] d_data
);
  localparam logic        IDLE = 1'b0;
  localparam logic        RESP = 1'b1;
  localparam int          IW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
  logic        state_q, state_d;
  logic [2:0]  d_opcode_q, d_opcode_d, d_size_q, d_size_d;
  logic [3:0]  d_source_q, d_source_d;
  logic        d_denied_q, d_denied_d;
  logic [63:0] d_data_q, d_data_d;
  logic [63:0] mem_q [DEPTH];
  logic [63:0] off;
  logic [IW-1:0] idx;
  logic        accept, is_get, is_put, aligned, deny;
  assign d_valid  = state_q == RESP;
  assign a_ready  = ~rst & ((state_q == IDLE) | (d_valid & d_ready));
  assign d_opcode = d_opcode_q;
  assign d_size   = d_size_q;
  assign d_source = d_source_q;
  assign d_denied = d_denied_q;
  assign d_data   = d_data_q;
  always_comb begin
    off        = a_address - BASE;
    idx        = off[IW+2:3];
    is_get     = a_opcode == 3'd4;
    is_put     = (a_opcode == 3'd0) | (a_opcode == 3'd1);
    aligned    = (a_address[2:0] & ~(3'h7 << a_size)) == 3'd0;
    deny       = ~(is_get | is_put) | (a_size > 3'd3) | ~aligned | (a_address < BASE) | (off >= SPAN);
    accept     = a_valid & a_ready;
    state_d    = accept ? RESP : (d_ready ? IDLE : state_q);
    d_opcode_d = accept ? {2'b0, is_get} : d_opcode_q;
    d_size_d   = accept ? a_size : d_size_q;
    d_source_d = accept ? a_source : d_source_q;
    d_denied_d = accept ? deny : d_denied_q;
    d_data_d   = accept ? ((is_get & ~deny) ? mem_q[idx] : 64'd0) : d_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      d_opcode_q <= 3'd0;
      d_size_q   <= 3'd0;
      d_source_q <= 4'd0;
      d_denied_q <= 1'b0;
      d_data_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_denied_q <= d_denied_d;
      d_data_q   <= d_data_d;
    end
  end
  // storage is deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (accept & is_put & ~deny & a_mask[i]) mem_q[idx][8*i +: 8] <= a_data[8*i +: 8];
  end
endmodule

// File: tb/tb_tl_sram_resp.sv
// tb_tl_sram_resp: vector table, corner sequences and randomized traffic against a memory model
module tb_tl_sram_resp;
  localparam int          DEPTH = 16;
  localparam logic [63:0] B     = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
  } req_t;
  typedef struct {
    logic [2:0]  op;
    logic        den;
    logic [63:0] data;
  } rsp_t;
  typedef struct {
    req_t r;
    rsp_t e;
  } vec_t;

  logic        clk = 0, rst = 1;
  logic        a_valid = 0, a_ready, d_valid, d_ready = 0, d_denied;
  logic [2:0]  a_opcode = 0, a_size = 0, d_opcode, d_size;
  logic [3:0]  a_source = 0, d_source;
  logic [63:0] a_address = 0, a_data = 0, d_data;
  logic [7:0]  a_mask = 0;

  int total = 0, bad = 0;
  logic [63:0] m [DEPTH];
  vec_t tbl [15];

  tl_sram_resp #(.DEPTH(DEPTH), .BASE(B)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data)
  );

  always #5 clk = ~clk;

  function automatic req_t mk(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                              input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
    req_t q;
    q.op = op; q.size = size; q.src = src; q.addr = addr; q.mask = mask; q.data = data;
    return q;
  endfunction

  function automatic rsp_t rs(input logic [2:0] op, input logic den, input logic [63:0] data);
    rsp_t p;
    p.op = op; p.den = den; p.data = data;
    return p;
  endfunction

  // memory semantics: legality rules, byte-lane writes, whole-word reads
  task automatic model(input req_t q, output rsp_t p);
    int w;
    p.op   = (q.op == 3'd4) ? 3'd1 : 3'd0;
    p.den  = !(q.op == 3'd0 || q.op == 3'd1 || q.op == 3'd4) || q.size > 3'd3 ||
             (q.addr % (64'd1 << q.size)) != 0 || q.addr < B || q.addr >= B + 64'(8 * DEPTH);
    p.data = 64'd0;
    if (!p.den) begin
      w = int'((q.addr - B) / 8);
      if (q.op == 3'd4) p.data = m[w];
      else for (int i = 0; i < 8; i++) if (q.mask[i]) m[w][8*i +: 8] = q.data[8*i +: 8];
    end
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic drive(input req_t q);
    a_valid = 1; a_opcode = q.op; a_size = q.size; a_source = q.src;
    a_address = q.addr; a_mask = q.mask; a_data = q.data;
  endtask

  task automatic chk_rsp(input string n, input req_t q, input rsp_t e);
    chk({n, ".d_valid"}, d_valid, 1'b1);
    chk({n, ".d_opcode"}, d_opcode, e.op);
    chk({n, ".d_size"}, d_size, q.size);
    chk({n, ".d_source"}, d_source, q.src);
    chk({n, ".d_denied"}, d_denied, e.den);
    chk({n, ".d_data"}, d_data, e.data);
  endtask

  task automatic xact(input string n, input req_t q, input rsp_t e);
    rsp_t p;
    drive(q); d_ready = 1;
    #1 chk({n, ".a_ready"}, a_ready, 1'b1);
    model(q, p);
    @(posedge clk); #1;
    a_valid = 0;
    chk_rsp(n, q, e);
    @(posedge clk); #1;
    chk({n, ".idle"}, d_valid, 1'b0);
  endtask

  initial begin
    req_t q, q2;
    rsp_t p, p2;
    rsp_t bb [8];
    logic [2:0] ops [5];
    bit pend;
    req_t pq;
    rsp_t pp;
    bit fire, exp_rdy;
    ops = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd6};

    tbl[0]  = '{mk(0, 3, 3, B + 8,      8'hFF, 64'h1122334455667788), rs(0, 0, 64'd0)};
    tbl[1]  = '{mk(4, 3, 5, B + 8,      8'h00, 64'd0),                rs(1, 0, 64'h1122334455667788)};
    tbl[2]  = '{mk(1, 3, 2, B + 8,      8'h0F, 64'hAAAAAAAA_BBBBBBBB), rs(0, 0, 64'd0)};
    tbl[3]  = '{mk(4, 3, 6, B + 8,      8'h00, 64'd0),                rs(1, 0, 64'h11223344_BBBBBBBB)};
    tbl[4]  = '{mk(4, 3, 7, B + 8*DEPTH, 8'h00, 64'd0),               rs(1, 1, 64'd0)};
    tbl[5]  = '{mk(4, 2, 8, B + 2,      8'h00, 64'd0),                rs(1, 1, 64'd0)};
    tbl[6]  = '{mk(6, 3, 9, B + 8,      8'hFF, 64'hDEAD),             rs(0, 1, 64'd0)};
    tbl[7]  = '{mk(0, 3, 1, B - 8,      8'hFF, 64'hBEEF),             rs(0, 1, 64'd0)};
    tbl[8]  = '{mk(4, 3, 4, B + 8,      8'h00, 64'd0),                rs(1, 0, 64'h11223344_BBBBBBBB)};
    tbl[9]  = '{mk(4, 4, 4, B + 16,     8'h00, 64'd0),                rs(1, 1, 64'd0)};
    tbl[10] = '{mk(4, 0, 12, B + 13,    8'h00, 64'd0),                rs(1, 0, 64'h11223344_BBBBBBBB)};
    tbl[11] = '{mk(0, 1, 13, B + 26,    8'h0C, 64'h00000000_CAFE0000), rs(0, 0, 64'd0)};
    tbl[12] = '{mk(4, 3, 14, B + 24,    8'h00, 64'd0),                rs(1, 0, 64'h00000000_CAFE0000)};
    tbl[13] = '{mk(0, 3, 15, B + 124,   8'hFF, 64'h1),                rs(0, 1, 64'd0)};
    tbl[14] = '{mk(4, 3, 0, B + 120,    8'h00, 64'd0),                rs(1, 0, 64'd0)};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.d_valid", d_valid, 1'b0);
    chk("rst.d_opcode", d_opcode, 3'd0);
    chk("rst.d_size", d_size, 3'd0);
    chk("rst.d_source", d_source, 4'd0);
    chk("rst.d_denied", d_denied, 1'b0);
    chk("rst.d_data", d_data, 64'd0);
    rst = 0;
    #1 chk("rst.a_ready_after", a_ready, 1'b1);

    for (int w = 0; w < DEPTH; w++) xact("fill", mk(0, 3, 4'(w), B + 64'(8 * w), 8'hFF, 64'd0), rs(0, 0, 64'd0));

    for (int i = 0; i < 15; i++) xact($sformatf("vec%0d", i), tbl[i].r, tbl[i].e);

    // backpressure: response held while a new request waits
    q = mk(4, 3, 9, B + 8, 8'h00, 64'd0);
    model(q, p);
    drive(q); d_ready = 0;
    @(posedge clk); #1;
    q2 = mk(4, 3, 10, B + 24, 8'h00, 64'd0);
    drive(q2);
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp.a_ready_low", a_ready, 1'b0);
      @(posedge clk); #1;
      chk_rsp("bp.hold", q, p);
    end
    d_ready = 1;
    #1 chk("bp.a_ready_release", a_ready, 1'b1);
    model(q2, p2);
    @(posedge clk); #1;
    a_valid = 0;
    chk_rsp("bp.next", q2, p2);
    @(posedge clk); #1;
    chk("bp.idle", d_valid, 1'b0);

    // back-to-back Gets, one response per cycle
    d_ready = 1;
    for (int i = 0; i < 8; i++) begin
      q = mk(4, 3, 4'(i), B + 64'(8 * i), 8'h00, 64'd0);
      model(q, bb[i]);
      drive(q);
      #1 chk("b2b.a_ready", a_ready, 1'b1);
      @(posedge clk); #1;
      chk_rsp($sformatf("b2b%0d", i), q, bb[i]);
    end
    a_valid = 0;
    @(posedge clk); #1;
    chk("b2b.idle", d_valid, 1'b0);

    // reset with a response in flight and a request pending
    drive(mk(4, 3, 1, B + 8, 8'h00, 64'd0)); d_ready = 0;
    @(posedge clk); #1;
    chk("rr.d_valid_before", d_valid, 1'b1);
    drive(mk(0, 3, 2, B + 8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF));
    rst = 1;
    @(posedge clk); #1;
    chk("rr.d_valid", d_valid, 1'b0);
    chk("rr.d_opcode", d_opcode, 3'd0);
    chk("rr.d_source", d_source, 4'd0);
    chk("rr.d_size", d_size, 3'd0);
    chk("rr.d_denied", d_denied, 1'b0);
    chk("rr.d_data", d_data, 64'd0);
    rst = 0; a_valid = 0;
    #1 chk("rr.a_ready", a_ready, 1'b1);
    xact("rr.readback", mk(4, 3, 3, B + 8, 8'h00, 64'd0), rs(1, 0, 64'h11223344_BBBBBBBB));

    // randomized traffic with random backpressure
    pend = 0;
    for (int c = 0; c < 400; c++) begin
      int sz, o;
      sz = $urandom_range(0, 4);
      o = $urandom_range(0, 8 * DEPTH + 15);
      if ($urandom % 5 != 0) o = o & ~((1 << sz) - 1);
      q = mk(ops[$urandom_range(0, 4)], 3'(sz), 4'($urandom), ($urandom % 16 == 0) ? B - 64'd8 : B + 64'(o),
             8'($urandom), {$urandom, $urandom});
      if ($urandom % 4 != 0) drive(q); else a_valid = 0;
      d_ready = ($urandom % 3 != 0);
      exp_rdy = !pend || d_ready;
      #1 chk("rnd.a_ready", a_ready, exp_rdy);
      fire = a_valid && exp_rdy;
      if (fire) model(q, p);
      @(posedge clk); #1;
      if (pend && d_ready) pend = 0;
      if (fire) begin
        pend = 1; pq = q; pp = p;
      end
      chk("rnd.d_valid", d_valid, pend);
      if (pend) chk_rsp("rnd", pq, pp);
    end
    a_valid = 0; d_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("end.idle", d_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tl_sram_resp.md
TL_SRAM_RESP -- requirements
Module: tl_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 512, number of 64-bit words; power of two.
REQ-002 SHALL have parameter BASE, default 64'h0000_0000_8000_0000, byte address of word 0.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port a_valid  input  1  request valid.
REQ-006 SHALL have port a_ready  output  1  request accepted when a_valid & a_ready.
REQ-007 SHALL have port a_opcode  input  3  0=PutFullData, 1=PutPartialData, 4=Get.
REQ-008 SHALL have port a_size  input  3  log2 bytes.
REQ-009 SHALL have port a_source  input  4  requester tag.
REQ-010 SHALL have port a_address  input  64  byte address.
REQ-011 SHALL have port a_mask  input  8  byte-lane enables.
REQ-012 SHALL have port a_data  input  64  write data.
REQ-013 SHALL have port d_valid  output  1  response valid.
REQ-014 SHALL have port d_ready  input  1  response consumed when d_valid & d_ready.
REQ-015 SHALL have port d_opcode  output  3  0=AccessAck, 1=AccessAckData.
REQ-016 SHALL have ports d_size (3), d_source (4)  output  echo of accepted a_size/a_source.
REQ-017 SHALL have port d_denied  output  1  request rejected.
REQ-018 SHALL have port d_data  output  64  read data; 0 when not AccessAckData or denied.

Function
REQ-019 SHALL implement FSM IDLE/RESP; a_ready = (state==IDLE) | (d_valid & d_ready).
REQ-020 SHALL, on accept in IDLE, enter RESP next cycle with d_valid=1 (1-cycle latency).
REQ-021 SHALL hold all d_* outputs stable while d_valid & ~d_ready.
REQ-022 SHALL, on d_valid & d_ready with no accept, return to IDLE; with simultaneous accept, stay RESP and present the new response next cycle (back-to-back, one transfer/cycle).
REQ-023 SHALL deny (d_denied=1, no memory change) when: opcode not in {0,1,4}; a_size>3; address not aligned to 2^a_size; address outside [BASE, BASE+8*DEPTH).
REQ-024 SHALL index word (a_address-BASE)>>3, ignore address bits [2:0] for indexing.
REQ-025 SHALL, for Put not denied, write bytes where a_mask[i]=1 in the accept cycle; d_opcode=0.
REQ-026 SHALL, for Get, return whole 64-bit word with d_opcode=1; Get-after-Put back-to-back to same word returns written data.
REQ-027 SHALL set d_opcode per request opcode class even when denied (Get->1, others->0).
REQ-028 SHALL keep a_ready low in RESP while d_ready=0 (single outstanding, no buffering beyond one response).

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, d_valid=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_data=0; a_ready=1 from first cycle after rst drops.
REQ-030 SHALL discard any in-flight response on reset; memory contents are not cleared.
REQ-031 SHALL ignore a_valid during the rst=1 cycle (no write, no response).

Verification
REQ-032 Put opcode 0, addr BASE+8, mask FF, data 64'h1122334455667788, source 3 -> next cycle d_valid, d_opcode 0, d_source 3, d_denied 0; then Get BASE+8 size 3 -> d_data 64'h1122334455667788.
REQ-033 PutPartial addr BASE+8, mask 0x0F, data 64'hAAAAAAAA_BBBBBBBB -> subsequent Get returns 64'h11223344_BBBBBBBB.
REQ-034 Get to BASE+8*DEPTH, or Get size 2 at BASE+2, or opcode 6 -> d_denied 1, d_data 0, memory unchanged.
REQ-035 d_ready held 0 for 5 cycles with a_valid held 1 -> a_ready 0, d_* stable for all 5 cycles; d_ready then 1 -> new request accepted same cycle, response next cycle.
REQ-036 Continuous a_valid/d_ready=1, 8 Gets sources 0..7 -> 8 responses on 8 consecutive cycles, sources in order.
REQ-037 rst asserted while d_valid=1 -> d_valid 0 next cycle; prior Puts still readable after reset.
